me_best_match_tracker: RTL and testbench

- Parametrised successor to the motion-estimation distortion comparator.
- Watches the one-hot ready strobes from a PE array, selects the reporting PE's distortion, and tracks the minimum distortion and its motion vector over one search.
- Adds proper search control: start, candidate counting, done flag, protocol-error detection, and a pipelined select/compare.
- Sits between the PE array and the motion-vector output logic.

---
 rtl/me_best_match_tracker_if.sv | 28 ++
 rtl/me_best_match_tracker.sv | 172 +++++++++++++++++
 tb/tb_me_best_match_tracker.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/me_best_match_tracker_if.sv
// rtl/me_best_match_tracker_if.sv - PE array to best-match tracker bus
interface me_best_match_tracker_if #(
    parameter int NUM_PE = 16,
    parameter int DIST_W = 8,
    parameter int VEC_W  = 4
);
    logic                     start;
    logic [NUM_PE*DIST_W-1:0] peout;
    logic [NUM_PE-1:0]        peready;
    logic [VEC_W-1:0]         vectorx;
    logic [VEC_W-1:0]         vectory;
    logic [DIST_W-1:0]        bestdist;
    logic [VEC_W-1:0]         motionx;
    logic [VEC_W-1:0]         motiony;
    logic                     busy;
    logic                     done;
    logic                     proto_err;

    modport master (
        output start, peout, peready, vectorx, vectory,
        input  bestdist, motionx, motiony, busy, done, proto_err
    );

    modport slave (
        input  start, peout, peready, vectorx, vectory,
        output bestdist, motionx, motiony, busy, done, proto_err
    );
endinterface

// File: rtl/me_best_match_tracker.sv
// rtl/me_best_match_tracker.sv - pipelined minimum-distortion tracker; ME_TIE_CENTER_EN enables centre-distance tie break
module me_best_match_tracker #(
    parameter int NUM_PE   = 16,
    parameter int DIST_W   = 8,
    parameter int VEC_W    = 4,
    parameter int NUM_CAND = 256
) (
    input  logic                    clock,
    input  logic                    reset,
    me_best_match_tracker_if.slave  bus
);
    localparam int CNT_W = $clog2(NUM_CAND + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;

    logic                s1_valid;
    logic [DIST_W-1:0]   s1_dist;
    logic [VEC_W-1:0]    s1_vx;
    logic [VEC_W-1:0]    s1_vy;

    logic [DIST_W-1:0]   best;
    logic [VEC_W-1:0]    best_x;
    logic [VEC_W-1:0]    best_y;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic                err;

    logic [DIST_W-1:0]   sel_dist;
    logic                any_ready;
    logic                multi_hot;
    logic                accept;
    logic                better;
    logic                start_search;

`ifdef ME_TIE_CENTER_EN
    logic                best_valid;

    function automatic logic [VEC_W:0] centre_dist(input logic [VEC_W-1:0] x,
                                                   input logic [VEC_W-1:0] y);
        logic [VEC_W:0] c;
        logic [VEC_W:0] ex;
        logic [VEC_W:0] ey;
        logic [VEC_W:0] ax;
        logic [VEC_W:0] ay;
        c  = (VEC_W+1)'(1) << (VEC_W - 1);
        ex = {1'b0, x};
        ey = {1'b0, y};
        ax = (ex >= c) ? (ex - c) : (c - ex);
        ay = (ey >= c) ? (ey - c) : (c - ey);
        return ax + ay;
    endfunction
`endif

    always_comb begin
        sel_dist = '0;
        for (int i = NUM_PE - 1; i >= 0; i--) begin
            if (bus.peready[i]) begin
                sel_dist = bus.peout[i*DIST_W +: DIST_W];
            end
        end
    end

    assign any_ready    = |bus.peready;
    assign multi_hot    = |(bus.peready & (bus.peready - NUM_PE'(1)));
    assign accept       = (state == ST_SEARCH) && s1_valid;
    assign cnt_next     = cnt + CNT_W'(1);
    assign start_search = (state != ST_SEARCH) && bus.start;

`ifdef ME_TIE_CENTER_EN
    assign better = (s1_dist < best) ||
                    ((s1_dist == best) && best_valid &&
                     (centre_dist(s1_vx, s1_vy) < centre_dist(best_x, best_y)));
`else
    assign better = (s1_dist < best);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (accept && (cnt_next == CNT_W'(NUM_CAND))) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    state_next = ST_SEARCH;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_dist  <= '0;
            s1_vx    <= '0;
            s1_vy    <= '0;
            best     <= '1;
            best_x   <= '0;
            best_y   <= '0;
            cnt      <= '0;
            err      <= 1'b0;
`ifdef ME_TIE_CENTER_EN
            best_valid <= 1'b0;
`endif
        end else if (start_search) begin
            s1_valid <= 1'b0;
            best     <= '1;
            best_x   <= '0;
            best_y   <= '0;
            cnt      <= '0;
            err      <= 1'b0;
`ifdef ME_TIE_CENTER_EN
            best_valid <= 1'b0;
`endif
        end else if (state == ST_SEARCH) begin
            s1_valid <= any_ready;
            if (any_ready) begin
                s1_dist <= sel_dist;
                s1_vx   <= bus.vectorx;
                s1_vy   <= bus.vectory;
            end
            if (multi_hot) begin
                err <= 1'b1;
            end
            if (accept) begin
                cnt <= cnt_next;
                if (better) begin
                    best   <= s1_dist;
                    best_x <= s1_vx;
                    best_y <= s1_vy;
`ifdef ME_TIE_CENTER_EN
                    best_valid <= 1'b1;
`endif
                end
            end
        end else begin
            s1_valid <= 1'b0;
        end
    end

    assign bus.bestdist  = best;
    assign bus.motionx   = best_x;
    assign bus.motiony   = best_y;
    assign bus.busy      = (state == ST_SEARCH);
    assign bus.done      = (state == ST_DONE);
    assign bus.proto_err = err;
endmodule

// File: tb/tb_me_best_match_tracker.sv
// tb/tb_me_best_match_tracker.sv - self-checking bench for me_best_match_tracker
module tb_me_best_match_tracker;
    localparam int NUM_PE   = 16;
    localparam int DIST_W   = 8;
    localparam int VEC_W    = 4;
    localparam int NUM_CAND = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    me_best_match_tracker_if #(.NUM_PE(NUM_PE), .DIST_W(DIST_W), .VEC_W(VEC_W)) bus ();

    me_best_match_tracker #(
        .NUM_PE(NUM_PE), .DIST_W(DIST_W), .VEC_W(VEC_W), .NUM_CAND(NUM_CAND)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int m_phase = 0;
    int m_best  = 255;
    int m_mx    = 0;
    int m_my    = 0;
    int m_cnt   = 0;
    bit m_err   = 1'b0;
    bit m_found = 1'b0;
    bit p_valid = 1'b0;
    int p_dist  = 0;
    int p_vx    = 0;
    int p_vy    = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int cdist(input int x, input int y);
        return iabs(x - 8) + iabs(y - 8);
    endfunction

    function automatic bit beats(input int d, input int x, input int y);
`ifdef ME_TIE_CENTER_EN
        return (d < m_best) || (d == m_best && m_found && cdist(x, y) < cdist(m_mx, m_my));
`else
        return (d < m_best);
`endif
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_phase = 0; m_best = 255; m_mx = 0; m_my = 0; m_cnt = 0;
            m_err = 1'b0; m_found = 1'b0; p_valid = 1'b0;
        end else if (m_phase == 1) begin
            if (p_valid) begin
                if (beats(p_dist, p_vx, p_vy)) begin
                    m_best = p_dist; m_mx = p_vx; m_my = p_vy; m_found = 1'b1;
                end
                m_cnt++;
                if (m_cnt == NUM_CAND) m_phase = 2;
            end
            p_valid = (bus.peready != 0);
            if (p_valid) begin
                for (int i = 0; i < NUM_PE; i++) begin
                    if (bus.peready[i]) begin
                        p_dist = int'(bus.peout[i*DIST_W +: DIST_W]);
                        break;
                    end
                end
                p_vx = int'(bus.vectorx);
                p_vy = int'(bus.vectory);
                if ($countones(bus.peready) > 1) m_err = 1'b1;
            end
        end else begin
            p_valid = 1'b0;
            if (bus.start) begin
                m_phase = 1; m_best = 255; m_mx = 0; m_my = 0; m_cnt = 0;
                m_err = 1'b0; m_found = 1'b0;
            end
        end
        cmp_en = 1'b1;
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            check("model",
                  {13'd0, bus.bestdist, bus.motionx, bus.motiony, bus.busy, bus.done, bus.proto_err},
                  (m_best << 11) | (m_mx << 7) | (m_my << 3) |
                  ((m_phase == 1 ? 1 : 0) << 2) | ((m_phase == 2 ? 1 : 0) << 1) | int'(m_err));
        end
    end

    function automatic logic [NUM_PE*DIST_W-1:0] lane(input int l, input int d);
        logic [NUM_PE*DIST_W-1:0] v;
        v = '0;
        v[l*DIST_W +: DIST_W] = DIST_W'(d);
        return v;
    endfunction

    task automatic step(input bit s, input logic [NUM_PE-1:0] pr,
                        input logic [NUM_PE*DIST_W-1:0] po, input int vx, input int vy);
        bus.start   = s;
        bus.peready = pr;
        bus.peout   = po;
        bus.vectorx = VEC_W'(vx);
        bus.vectory = VEC_W'(vy);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, 0, 0);
    endtask

    task automatic cand(input int d, input int vx, input int vy);
        step(1'b0, 16'h0001, lane(0, d), vx, vy);
    endtask

    initial begin
        bus.start = 1'b0; bus.peready = '0; bus.peout = '0; bus.vectorx = '0; bus.vectory = '0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("reset_best", int'(bus.bestdist), 255);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        reset = 1'b0;

        idle(1);
        step(1'b0, 16'h0001, lane(0, 3), 1, 1);
        idle(2);
        check("idle_ignored", int'(bus.bestdist), 255);

        step(1'b1, 16'h0001, lane(0, 7), 9, 9);
        check("start_busy", int'(bus.busy), 1);
        check("start_best", int'(bus.bestdist), 255);
        cand(50, 1, 1); cand(30, 2, 2); cand(30, 3, 3); cand(40, 4, 4);
        idle(1);
        check("t1_best", int'(bus.bestdist), 30);
        check("t1_mx", int'(bus.motionx), 2);
        check("t1_my", int'(bus.motiony), 2);
        check("t1_done", int'(bus.done), 1);
        check("t1_busy", int'(bus.busy), 0);
        check("t1_err", int'(bus.proto_err), 0);
        cand(1, 9, 9);
        idle(2);
        check("done_ignored", int'(bus.bestdist), 30);

        step(1'b1, '0, '0, 0, 0);
        check("restart_best", int'(bus.bestdist), 255);
        check("restart_done", int'(bus.done), 0);
        check("restart_busy", int'(bus.busy), 1);
        step(1'b0, 16'h8000, lane(15, 5), 3, 3);
        step(1'b1, '0, '0, 0, 0);
        check("lane15_best", int'(bus.bestdist), 5);
        check("start_in_search", int'(bus.busy), 1);
        cand(200, 1, 1); cand(200, 1, 1); cand(200, 1, 1);
        idle(1);
        check("t2_done", int'(bus.done), 1);
        check("t2_mx", int'(bus.motionx), 3);

        step(1'b1, '0, '0, 0, 0);
        step(1'b0, 16'h0006, lane(1, 20) | lane(2, 10), 5, 6);
        check("mh_err", int'(bus.proto_err), 1);
        idle(1);
        check("mh_best", int'(bus.bestdist), 20);
        check("mh_mx", int'(bus.motionx), 5);
        cand(100, 1, 1); cand(100, 1, 1); cand(100, 1, 1);
        idle(1);
        check("mh_done", int'(bus.done), 1);
        check("mh_sticky", int'(bus.proto_err), 1);
        step(1'b1, '0, '0, 0, 0);
        check("mh_clear", int'(bus.proto_err), 0);

        cand(10, 1, 2); cand(20, 3, 4);
        idle(1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("rst_best", int'(bus.bestdist), 255);
        check("rst_mx", int'(bus.motionx), 0);
        check("rst_busy", int'(bus.busy), 0);
        cand(5, 1, 1); cand(5, 1, 1);
        idle(2);
        check("rst_ignored", int'(bus.bestdist), 255);

        step(1'b1, '0, '0, 0, 0);
        cand(255, 7, 7); cand(255, 6, 6); cand(255, 8, 8); cand(255, 5, 5);
        idle(1);
        check("ones_best", int'(bus.bestdist), 255);
        check("ones_mx", int'(bus.motionx), 0);
        check("ones_done", int'(bus.done), 1);

        step(1'b1, '0, '0, 0, 0);
        cand(30, 0, 0); cand(30, 8, 7); cand(255, 8, 8); cand(255, 8, 8);
        idle(1);
        check("tie_done", int'(bus.done), 1);
`ifdef ME_TIE_CENTER_EN
        check("tie_mx", int'(bus.motionx), 8);
        check("tie_my", int'(bus.motiony), 7);
`else
        check("tie_mx", int'(bus.motionx), 0);
        check("tie_my", int'(bus.motiony), 0);
`endif
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
